// File: rtl/fifo_burst_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader_pkg
//
// Shared definitions for the FIFO burst reader and its skid buffer:
//   - state_t and ST_* constants : 2-bit state encoding of the burst FSM
//   - SKID_DEPTH                 : number of entries in the output skid buffer
//   - skid_occupancy()           : buffered + in-flight words after this cycle's accept
// ---------------------------------------------------------------------------
package fifo_burst_reader_pkg;

    // Burst FSM encoding, kept as plain constants so older code that compares
    // raw 2-bit state values keeps working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Two entries are enough to cover the one-cycle FIFO read latency while
    // still sustaining one word per cycle.
    localparam int SKID_DEPTH = 2;

    // Words that will occupy the skid buffer once this cycle's accept has
    // left and the in-flight word has landed. A new pop is only safe while
    // this stays below SKID_DEPTH.
    function automatic logic [2:0] skid_occupancy(
        input logic [1:0] buf_count,
        input logic       inflight,
        input logic       accept
    );
        return {1'b0, buf_count} + {2'b00, inflight} - {2'b00, accept};
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
//
// Two-entry FIFO-ordered buffer between the upstream FIFO read port and the
// downstream stream. A push and a pop in the same cycle are both honoured,
// including when the buffer is full.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears contents)
//   push         : enqueue push_data this cycle
//   push_data    : word to enqueue
//   pop          : dequeue the head word this cycle
//   count        : number of valid entries (0..2)
//   head         : oldest entry (meaningful only while count != 0)
// ---------------------------------------------------------------------------
module stream_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);
    import fifo_burst_reader_pkg::*;

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees the head slot this cycle, so a full buffer can still take
    // a push when it is popped at the same time.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'(SKID_DEPTH)) || do_pop);

    // Storage, pointers and occupancy; contents are cleared on reset so that
    // stale words never reappear on the stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//
// Reads a burst of burst_len words from an upstream FIFO (one-cycle read
// latency) and presents them as a valid/ready stream, flagging the final
// word with m_last and pulsing done once the burst has been delivered.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : burst request pulse, honoured only when idle
//   burst_len    : number of words in the burst, sampled with start
//   fifo_empty   : upstream FIFO empty flag
//   fifo_r_en    : upstream FIFO read strobe (combinational)
//   fifo_rdata   : upstream read data, valid the cycle after a pop
//   m_valid      : stream word valid
//   m_ready      : downstream accept
//   m_data       : stream word (zero while m_valid is low)
//   m_last       : final word of the burst
//   busy         : a burst is in progress
//   done         : one-cycle pulse when the burst completes
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    import fifo_burst_reader_pkg::*;

    state_t                state;
    state_t                next_state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  delivered;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  accept;
    logic                  pop;
    logic                  start_ok;

    assign start_ok = (state == ST_IDLE) && start && (burst_len != '0);
    assign accept   = m_valid && m_ready;

    // Read strobe: only in READ, only while words remain to be issued, and
    // only if the word will have a free skid slot when it lands next cycle.
    // Gated by reset so nothing is popped in the reset cycle itself.
    assign fifo_r_en = (state == ST_READ)
                    && !fifo_empty
                    && (issued < len_q)
                    && (skid_occupancy(buf_count, inflight, accept) < 3'd2)
                    && !reset;

    assign pop = fifo_r_en && !fifo_empty;

    // The popped word arrives one cycle later and is pushed into the skid
    // buffer on the same edge that any accepted head word leaves it.
    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (accept),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign m_valid = (buf_count != 2'd0);
    assign m_data  = m_valid ? buf_head : '0;
    assign m_last  = m_valid && (delivered == (len_q - LEN_WIDTH'(1)));
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // Next-state logic. READ hands over to DRAIN once every word has been
    // issued; the remaining words are delivered from the skid buffer.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (issued == len_q) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && m_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, burst length and progress counters. A new burst clears the
    // counters; otherwise issued follows pops and delivered follows accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= pop;
            if (start_ok) begin
                len_q     <= burst_len;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (pop) begin
                    issued <= issued + LEN_WIDTH'(1);
                end
                if (accept) begin
                    delivered <= delivered + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Self-checking bench for fifo_burst_reader. An upstream FIFO model feeds the
// design; a negedge monitor records every accepted word, done pulse and
// protocol violation; each test task compares the recorded stream with the
// words it pushed into the FIFO for that burst.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [LW-1:0] burst_len  = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_valid;
    logic          m_ready    = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc        = 0;
    int pop_cnt    = 0;
    int done_cnt   = 0;
    int done_cyc   = 0;
    int busy_cnt   = 0;
    int bad_ren    = 0;
    int stall_viol = 0;
    int zero_viol  = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] acc_data[$];
    logic          acc_last[$];
    int            acc_cyc[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Upstream FIFO: a pop presents the front word on the next cycle.
    always @(posedge clk) begin
        cyc++;
        if (fifo_r_en && !fifo_empty) begin
            pop_cnt++;
            if (fifo_q.size() > 0) begin
                fifo_rdata <= fifo_q.pop_front();
            end
        end
        #2;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fifo_r_en && fifo_empty) bad_ren++;
        if (!m_valid && ((m_data !== '0) || m_last)) zero_viol++;
        if (prev_stall && (!m_valid || (m_data !== prev_data))) stall_viol++;
        prev_stall = m_valid && !m_ready && !reset;
        prev_data  = m_data;
        if (m_valid && m_ready) begin
            acc_data.push_back(m_data);
            acc_last.push_back(m_last);
            acc_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon;
        pop_cnt    = 0;
        done_cnt   = 0;
        done_cyc   = 0;
        busy_cnt   = 0;
        bad_ren    = 0;
        stall_viol = 0;
        zero_viol  = 0;
        acc_data.delete();
        acc_last.delete();
        acc_cyc.delete();
    endtask

    task automatic start_burst(input logic [LW-1:0] len, output int sc);
        sc        = cyc;
        start     = 1'b1;
        burst_len = len;
        tick(1);
        start     = 1'b0;
        burst_len = '0;
    endtask

    task automatic wait_done(input int budget);
        int waited;
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            tick(1);
            waited++;
        end
        tick(3);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        m_ready = 1'b0;
        tick(3);
        n_checks++;
        if ({fifo_r_en, m_valid, m_last, busy, done} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {fifo_r_en, m_valid, m_last, busy, done});
        end
        n_checks++;
        if (m_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 00", m_data);
        end
        reset = 1'b0;
        tick(2);
        n_checks++;
        if ({fifo_r_en, m_valid, busy, done} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_flags: got %b expected 0000", {fifo_r_en, m_valid, busy, done});
        end
    endtask

    task automatic test_basic;
        int sc;
        clear_mon();
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h11 + i));
        m_ready = 1'b1;
        tick(1);
        start_burst(LW'(4), sc);
        wait_done(20);
        n_checks++;
        if (acc_data.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL basic_count: got %0d expected 4", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 4; i++) begin
            n_checks++;
            if (acc_data[i] !== DW'(8'h11 + i) || acc_last[i] !== (i == 3) || acc_cyc[i] !== sc + 3 + i) begin
                n_fail++;
                $display("[TB] FAIL basic_word%0d: got data %h last %b cyc %0d expected %h %b %0d",
                         i, acc_data[i], acc_last[i], acc_cyc[i], DW'(8'h11 + i), (i == 3), sc + 3 + i);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== sc + 7) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, sc + 7);
        end
    endtask

    task automatic test_stall;
        int sc;
        clear_mon();
        for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(8'h11 + i));
        m_ready = 1'b0;
        tick(1);
        start_burst(LW'(3), sc);
        tick(4);
        n_checks++;
        if (pop_cnt !== 2) begin
            n_fail++;
            $display("[TB] FAIL stall_pops: got %0d expected 2", pop_cnt);
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11 || stall_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL stall_hold: got valid %b data %h viol %0d expected 1 11 0", m_valid, m_data, stall_viol);
        end
        m_ready = 1'b1;
        wait_done(20);
        n_checks++;
        if (acc_data.size() !== 3 || pop_cnt !== 3) begin
            n_fail++;
            $display("[TB] FAIL stall_count: got %0d words %0d pops expected 3 3", acc_data.size(), pop_cnt);
        end
        for (int i = 0; i < acc_data.size() && i < 3; i++) begin
            n_checks++;
            if (acc_data[i] !== DW'(8'h11 + i) || acc_last[i] !== (i == 2)) begin
                n_fail++;
                $display("[TB] FAIL stall_word%0d: got %h last %b expected %h %b", i, acc_data[i], acc_last[i], DW'(8'h11 + i), (i == 2));
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL stall_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_underflow;
        int sc;
        clear_mon();
        fifo_q.push_back(8'h21);
        m_ready = 1'b1;
        tick(1);
        start_burst(LW'(3), sc);
        tick(5);
        n_checks++;
        if (pop_cnt !== 1 || acc_data.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL under_wait: got %0d pops %0d words expected 1 1", pop_cnt, acc_data.size());
        end
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h23);
        wait_done(20);
        n_checks++;
        if (bad_ren !== 0) begin
            n_fail++;
            $display("[TB] FAIL under_ren_empty: got %0d expected 0", bad_ren);
        end
        n_checks++;
        if (acc_data.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL under_count: got %0d expected 3", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 3; i++) begin
            n_checks++;
            if (acc_data[i] !== DW'(8'h21 + i) || acc_last[i] !== (i == 2)) begin
                n_fail++;
                $display("[TB] FAIL under_word%0d: got %h last %b expected %h %b", i, acc_data[i], acc_last[i], DW'(8'h21 + i), (i == 2));
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL under_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_zero_len;
        int sc;
        clear_mon();
        fifo_q.push_back(8'h31);
        m_ready = 1'b1;
        tick(1);
        start_burst('0, sc);
        tick(6);
        n_checks++;
        if (busy_cnt !== 0 || pop_cnt !== 0 || done_cnt !== 0 || acc_data.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_len: got busy %0d pops %0d done %0d words %0d expected all 0",
                     busy_cnt, pop_cnt, done_cnt, acc_data.size());
        end
        fifo_q.delete();
        tick(1);
    endtask

    task automatic test_mid_reset;
        int sc;
        int waited;
        clear_mon();
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h41 + i));
        m_ready = 1'b0;
        tick(1);
        start_burst(LW'(4), sc);
        waited = 0;
        while (pop_cnt < 2 && waited < 10) begin
            tick(1);
            waited++;
        end
        n_checks++;
        if (pop_cnt !== 2 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mreset_pre: got pops %0d busy %b expected 2 1", pop_cnt, busy);
        end
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        m_ready = 1'b1;
        n_checks++;
        if ({fifo_r_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL mreset_out: got flags %b data %h expected 00000 00",
                     {fifo_r_en, m_valid, m_last, busy, done}, m_data);
        end
        tick(3);
        n_checks++;
        if (acc_data.size() !== 0 || done_cnt !== 0 || pop_cnt !== 2) begin
            n_fail++;
            $display("[TB] FAIL mreset_quiet: got words %0d done %0d pops %0d expected 0 0 2",
                     acc_data.size(), done_cnt, pop_cnt);
        end
        fifo_q.delete();
        fifo_q.push_back(8'h5A);
        tick(1);
        clear_mon();
        start_burst(LW'(1), sc);
        wait_done(20);
        n_checks++;
        if (acc_data.size() !== 1 || done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL mreset_after: got words %0d done %0d expected 1 1", acc_data.size(), done_cnt);
        end else begin
            n_checks++;
            if (acc_data[0] !== 8'h5A || acc_last[0] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL mreset_word: got %h last %b expected 5a 1", acc_data[0], acc_last[0]);
            end
        end
    endtask

    task automatic test_start_in_drain;
        int sc;
        int waited;
        clear_mon();
        for (int i = 0; i < 7; i++) fifo_q.push_back(DW'(8'h61 + i));
        m_ready = 1'b0;
        tick(1);
        start_burst(LW'(2), sc);
        waited = 0;
        while (pop_cnt < 2 && waited < 10) begin
            tick(1);
            waited++;
        end
        tick(3);
        n_checks++;
        if (busy !== 1'b1 || pop_cnt !== 2) begin
            n_fail++;
            $display("[TB] FAIL drain_pre: got busy %b pops %0d expected 1 2", busy, pop_cnt);
        end
        start     = 1'b1;
        burst_len = LW'(5);
        tick(1);
        start     = 1'b0;
        burst_len = '0;
        m_ready   = 1'b1;
        tick(10);
        n_checks++;
        if (acc_data.size() !== 2 || done_cnt !== 1 || pop_cnt !== 2 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_ignore: got words %0d done %0d pops %0d busy %b expected 2 1 2 0",
                     acc_data.size(), done_cnt, pop_cnt, busy);
        end
        for (int i = 0; i < acc_data.size() && i < 2; i++) begin
            n_checks++;
            if (acc_data[i] !== DW'(8'h61 + i) || acc_last[i] !== (i == 1)) begin
                n_fail++;
                $display("[TB] FAIL drain_word%0d: got %h last %b expected %h %b", i, acc_data[i], acc_last[i], DW'(8'h61 + i), (i == 1));
            end
        end
        fifo_q.delete();
        tick(1);
    endtask

    task automatic test_max_len;
        int sc;
        int bad;
        clear_mon();
        for (int i = 0; i < 255; i++) fifo_q.push_back(DW'(i ^ 8'hA5));
        m_ready = 1'b1;
        tick(1);
        start_burst(LW'(255), sc);
        wait_done(400);
        n_checks++;
        if (acc_data.size() !== 255 || done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL max_count: got words %0d done %0d expected 255 1", acc_data.size(), done_cnt);
        end
        bad = 0;
        for (int i = 0; i < acc_data.size(); i++) begin
            if (acc_data[i] !== DW'(i ^ 8'hA5) || acc_last[i] !== (i == 254)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL max_words: got %0d wrong words expected 0", bad);
        end
        n_checks++;
        if (acc_cyc.size() == 255 && acc_cyc[254] !== sc + 3 + 254) begin
            n_fail++;
            $display("[TB] FAIL max_rate: got last word at %0d expected %0d", acc_cyc[254], sc + 3 + 254);
        end
    endtask

    task automatic test_random;
        int len;
        int sc;
        int pushed;
        int waited;
        int bad;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_q[$];
        for (int b = 0; b < 15; b++) begin
            clear_mon();
            exp_q.delete();
            len    = $urandom_range(1, 20);
            pushed = 0;
            start_burst(LW'(len), sc);
            waited = 0;
            while (done_cnt == 0 && waited < 400) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if (pushed < len && $urandom_range(0, 2) != 0) begin
                    w = DW'($urandom);
                    fifo_q.push_back(w);
                    exp_q.push_back(w);
                    pushed++;
                end
                tick(1);
                waited++;
            end
            m_ready = 1'b1;
            tick(3);
            n_checks++;
            if (done_cnt !== 1 || acc_data.size() !== len) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_count: got done %0d words %0d expected 1 %0d", b, done_cnt, acc_data.size(), len);
            end
            bad = 0;
            for (int i = 0; i < acc_data.size(); i++) begin
                if (i >= exp_q.size() || acc_data[i] !== exp_q[i] || acc_last[i] !== (i == len - 1)) bad++;
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_words: got %0d wrong words expected 0", b, bad);
            end
            n_checks++;
            if (bad_ren !== 0 || stall_viol !== 0 || zero_viol !== 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_proto: got ren %0d stall %0d zero %0d expected 0 0 0", b, bad_ren, stall_viol, zero_viol);
            end
        end
    endtask

    initial begin
        $display("[TB] fifo_burst_reader bench starting");
        test_reset();
        test_basic();
        test_stall();
        test_underflow();
        test_zero_len();
        test_mid_reset();
        test_start_in_drain();
        test_max_len();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
